tagged_stream_combiner: RTL

- N-channel successor to the two-input message/sample combiner.
- Each input stream has its own FIFO; a round-robin arbiter drains the FIFOs into one output stream.
- Output is a sequence of packets: one header word carrying channel id and length, then that many sample words.
- Sits after channelised DSP blocks, ahead of the serialiser, feeding the downstream splitter, which keys on the header MSB.

---
 rtl/tsc_pkg.sv | 38 +++
 rtl/tagged_stream_combiner_if.sv | 14 +
 rtl/stream_fifo.sv | 50 +++++
 rtl/tagged_stream_combiner.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared header layout, FSM encoding and header builder for the tagged stream combiner.
package tsc_pkg;

    localparam int HDR_MAX_W   = 64;
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    function automatic int unsigned hdr_flag_pos(input int unsigned wdth);
        return wdth - 1;
    endfunction

    function automatic int unsigned hdr_ch_lsb(input int unsigned wdth, input int unsigned log_n);
        return wdth - 1 - log_n;
    endfunction

    // Built at the widest supported word; callers size-cast down to their WDTH.
    function automatic logic [HDR_MAX_W-1:0] build_hdr(
        input int unsigned ch,
        input int unsigned len,
        input int unsigned wdth,
        input int unsigned log_n,
        input int unsigned len_w
    );
        logic [HDR_MAX_W-1:0] h;
        logic [HDR_MAX_W-1:0] len_mask;
        len_mask = (HDR_MAX_W'(1) << len_w) - HDR_MAX_W'(1);
        h = HDR_MAX_W'(1) << hdr_flag_pos(wdth);
        h = h | (HDR_MAX_W'(ch) << hdr_ch_lsb(wdth, log_n));
        h = h | ((HDR_MAX_W'(len) & len_mask) << HDR_LEN_LSB);
        return h;
    endfunction

endpackage

// File: rtl/tagged_stream_combiner_if.sv
// Channelised input strobes/words and the single packetised output stream.
interface tagged_stream_combiner_if #(
    parameter int N_STREAMS = 4,
    parameter int WDTH      = 32
);
    logic [N_STREAMS*WDTH-1:0] in_data;
    logic [N_STREAMS-1:0]      in_nd;
    logic [WDTH-1:0]           out_data;
    logic                      out_nd;
    logic                      error;

    modport master (output in_data, output in_nd, input out_data, input out_nd, input error);
    modport slave  (input in_data, input in_nd, output out_data, output out_nd, output error);
endinterface

// File: rtl/stream_fifo.sv
// Single-clock FIFO with occupancy count; read data is the current head (fall-through).
// Latency: a write is visible in count and rd_dat on the next cycle.
// Backpressure: none; writes when full and reads when empty are ignored, callers gate them.
module stream_fifo #(
    parameter int WDTH      = 32,
    parameter int DEPTH     = 16,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [WDTH-1:0]      wr_dat,
    input  logic                 rd_en,
    output logic [WDTH-1:0]      rd_dat,
    output logic [LOG_DEPTH:0]   count,
    output logic                 full,
    output logic                 empty
);
    logic [WDTH-1:0]      mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 wr_ok;
    logic                 rd_ok;

    assign full   = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty  = (count == '0);
    assign wr_ok  = wr_en && !full;
    assign rd_ok  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok)
                count <= count + 1'b1;
            else if (rd_ok && !wr_ok)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !reset) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/tagged_stream_combiner.sv
// Round-robin packetiser: per-channel FIFOs drained as header + up to MAX_PKT samples.
// Latency: in_nd at cycle 0 -> header at cycle 2 -> first sample at cycle 3; one idle cycle between packets.
// Backpressure: none; full-FIFO writes and MSB-set words are dropped and raise the sticky error.
module tagged_stream_combiner
    import tsc_pkg::*;
#(
    parameter int N_STREAMS     = 4,
    parameter int LOG_N_STREAMS = 2,
    parameter int WDTH          = 32,
    parameter int BUF_LEN       = 16,
    parameter int LOG_BUF_LEN   = 4,
    parameter int MAX_PKT       = 8,
    parameter int LEN_W         = 4,
    parameter int MIN_FILL      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    tagged_stream_combiner_if.slave   bus
);
    localparam int CNT_W = LOG_BUF_LEN + 1;

    logic [WDTH-1:0]                   fifo_rd_dat [N_STREAMS];
    logic [CNT_W-1:0]                  fifo_count  [N_STREAMS];
    logic [N_STREAMS-1:0]              fifo_full;
    logic [N_STREAMS-1:0]              fifo_empty;
    logic [N_STREAMS-1:0]              wr_en;
    logic [N_STREAMS-1:0]              rd_en;
    logic [N_STREAMS-1:0]              bad_wr;
    logic [(1<<LOG_N_STREAMS)-1:0]     eligible;

    state_t                            state_q, state_d;
    logic [LOG_N_STREAMS-1:0]          rr_ptr;
    logic [LOG_N_STREAMS-1:0]          cur_ch;
    logic [LEN_W-1:0]                  remaining;
    logic [WDTH-1:0]                   out_data_q;
    logic                              out_nd_q;
    logic                              error_q;

    logic                              grant_vld;
    logic [LOG_N_STREAMS-1:0]          grant_ch;
    logic [LOG_N_STREAMS-1:0]          scan_idx;
    int                                scan_sum;
    logic [CNT_W-1:0]                  grant_cnt;
    logic [LEN_W-1:0]                  grant_len;
    logic [WDTH-1:0]                   hdr_word;
    logic                              ld_hdr;
    logic                              pop;

    for (genvar k = 0; k < N_STREAMS; k++) begin : g_ch
        logic [WDTH-1:0] word;
        assign word      = bus.in_data[k*WDTH +: WDTH];
        // The full test uses the pre-cycle count, so a same-cycle read does not rescue a write.
        assign wr_en[k]  = bus.in_nd[k] && !word[WDTH-1] && !fifo_full[k];
        assign bad_wr[k] = bus.in_nd[k] && (word[WDTH-1] || fifo_full[k]);
        assign rd_en[k]  = pop && (cur_ch == LOG_N_STREAMS'(k)) && !fifo_empty[k];

        stream_fifo #(
            .WDTH      (WDTH),
            .DEPTH     (BUF_LEN),
            .LOG_DEPTH (LOG_BUF_LEN)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (wr_en[k]),
            .wr_dat (word),
            .rd_en  (rd_en[k]),
            .rd_dat (fifo_rd_dat[k]),
            .count  (fifo_count[k]),
            .full   (fifo_full[k]),
            .empty  (fifo_empty[k])
        );
    end

    always_comb begin
        eligible = '0;
        for (int k = 0; k < N_STREAMS; k++)
            eligible[k] = (fifo_count[k] >= CNT_W'(MIN_FILL));
    end

    // Search begins one past the last winner and wraps mod N_STREAMS.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        scan_idx  = '0;
        scan_sum  = 0;
        for (int i = 1; i <= N_STREAMS; i++) begin
            scan_sum = int'(rr_ptr) + i;
            if (scan_sum >= N_STREAMS) scan_sum = scan_sum - N_STREAMS;
            scan_idx = scan_sum[LOG_N_STREAMS-1:0];
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_ch  = scan_idx;
            end
        end
    end

    assign grant_cnt = fifo_count[grant_ch];
    assign grant_len = (grant_cnt > CNT_W'(MAX_PKT)) ? LEN_W'(MAX_PKT) : LEN_W'(grant_cnt);
    assign hdr_word  = WDTH'(build_hdr(32'(grant_ch), 32'(grant_len), WDTH, LOG_N_STREAMS, LEN_W));

    // State names what the output register shows next: HDR pops the first sample behind the header.
    always_comb begin
        state_d = state_q;
        ld_hdr  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    ld_hdr  = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                pop     = 1'b1;
                state_d = ST_BODY;
            end
            ST_BODY: begin
                if (remaining != '0)
                    pop = 1'b1;
                else
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr     <= LOG_N_STREAMS'(N_STREAMS - 1);
            cur_ch     <= '0;
            remaining  <= '0;
            out_data_q <= '0;
            out_nd_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_nd_q <= ld_hdr | pop;
            if (|bad_wr) error_q <= 1'b1;
            if (ld_hdr) begin
                cur_ch     <= grant_ch;
                rr_ptr     <= grant_ch;
                remaining  <= grant_len;
                out_data_q <= hdr_word;
            end else if (pop) begin
                out_data_q <= fifo_rd_dat[cur_ch];
                remaining  <= remaining - 1'b1;
            end
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.out_nd   = out_nd_q;
    assign bus.error    = error_q;

endmodule
